// File: rtl/i2c_master_write_frame.sv
// I2C master bit engine: START, STOP, master ACK/NACK and multi-byte writes with slave-ACK check.
// Bus drive (scl, sda_low) is registered from the phase decode, so the pins trail the phase counter by one cycle.
module i2c_master_write_frame #(
    parameter int BYTES     = 1,
    parameter int QUARTER   = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    input  logic [2:0]         command,
    input  logic [8*BYTES-1:0] data,
    input  logic               sda_i,
    output logic               busy,
    output logic               finish,
    output logic               ack_error,
    output logic               scl,
    output logic               sda_low
);

    localparam int DW = 8 * BYTES;
    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_DATA  = 3'b011;
    localparam logic [2:0] CMD_ACK   = 3'b111;
    localparam logic [2:0] CMD_NACK  = 3'b101;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DBIT,
        S_SACK,
        S_MACK,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          start_state;
    logic [2:0]      cmd_q;
    logic [DW-1:0]   shift_q;
    logic [DW-1:0]   shift_d;
    logic [QW-1:0]   qcnt_q;
    logic [1:0]      phase_q;
    logic [2:0]      bit_q;
    logic [BW-1:0]   byte_q;
    logic            busy_q;
    logic            finish_q;
    logic            ack_error_q;
    logic            scl_q;
    logic            sda_low_q;
    logic            scl_d;
    logic            sda_low_d;
    logic            cur_bit;
    logic            q_last;
    logic            bit_end;
    logic            accept;

    assign cur_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DW-1];
    assign shift_d = (LSB_FIRST != 0) ? {1'b0, shift_q[DW-1:1]} : {shift_q[DW-2:0], 1'b0};
    assign q_last  = (qcnt_q == QW'(QUARTER - 1));
    assign bit_end = q_last && (phase_q == 2'd3);

    always_comb begin
        start_state = S_IDLE;
        case (command)
            CMD_START: start_state = S_START;
            CMD_DATA:  start_state = S_DBIT;
            CMD_ACK:   start_state = S_MACK;
            CMD_NACK:  start_state = S_MNACK;
            CMD_STOP:  start_state = S_STOP;
            default:   start_state = S_IDLE;
        endcase
    end

    // The finish cycle is excluded so a go presented alongside finish is dropped.
    assign accept = go && !busy_q && !finish_q && (state_q == S_IDLE) && (start_state != S_IDLE);

    always_comb begin
        scl_d     = scl_q;
        sda_low_d = sda_low_q;
        case (state_q)
            S_START: begin
                scl_d     = 1'b1;
                sda_low_d = phase_q[1];
            end
            S_DBIT: begin
                scl_d     = phase_q[1];
                sda_low_d = ~cur_bit;
            end
            S_SACK: begin
                scl_d     = phase_q[1];
                sda_low_d = 1'b0;
            end
            S_MACK: begin
                scl_d     = phase_q[1];
                sda_low_d = 1'b1;
            end
            S_MNACK: begin
                scl_d     = phase_q[1];
                sda_low_d = 1'b0;
            end
            S_STOP: begin
                scl_d     = (phase_q != 2'd0);
                sda_low_d = ~phase_q[1];
            end
            S_DONE: begin
                // Mid-transfer commands leave SCL held low so the slave cannot run ahead.
                if (cmd_q != CMD_START && cmd_q != CMD_STOP) begin
                    scl_d = 1'b0;
                end
            end
            default: begin
                scl_d     = scl_q;
                sda_low_d = sda_low_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 3'b000;
            shift_q     <= '0;
            qcnt_q      <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 3'd0;
            byte_q      <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            ack_error_q <= 1'b0;
            scl_q       <= 1'b1;
            sda_low_q   <= 1'b0;
        end else begin
            finish_q  <= 1'b0;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= start_state;
                        cmd_q       <= command;
                        shift_q     <= data;
                        ack_error_q <= 1'b0;
                        busy_q      <= 1'b1;
                        qcnt_q      <= '0;
                        phase_q     <= 2'd0;
                        bit_q       <= 3'd0;
                        byte_q      <= '0;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    finish_q <= 1'b1;
                end
                default: begin
                    if (q_last) begin
                        qcnt_q  <= '0;
                        phase_q <= phase_q + 2'd1;
                    end else begin
                        qcnt_q <= qcnt_q + QW'(1);
                    end
                    if (bit_end) begin
                        case (state_q)
                            S_DBIT: begin
                                shift_q <= shift_d;
                                if (bit_q == 3'd7) begin
                                    bit_q   <= 3'd0;
                                    state_q <= S_SACK;
                                end else begin
                                    bit_q <= bit_q + 3'd1;
                                end
                            end
                            S_SACK: begin
                                if (sda_i) begin
                                    ack_error_q <= 1'b1;
                                    state_q     <= S_DONE;
                                end else if (byte_q == BW'(BYTES - 1)) begin
                                    state_q <= S_DONE;
                                end else begin
                                    byte_q  <= byte_q + BW'(1);
                                    state_q <= S_DBIT;
                                end
                            end
                            default: state_q <= S_DONE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign finish    = finish_q;
    assign ack_error = ack_error_q;
    assign scl       = scl_q;
    assign sda_low   = sda_low_q;

endmodule

// File: tb/tb_i2c_master_write_frame.sv
// Bench for i2c_master_write_frame: a bus monitor records SDA at every SCL rise and a slave model drives ACKs.
module tb_i2c_master_write_frame;

    localparam int Q     = 4;
    localparam int Q1    = 3;
    localparam int LIMIT = 4000;
    localparam logic [2:0] C_START = 3'b001;
    localparam logic [2:0] C_DATA  = 3'b011;
    localparam logic [2:0] C_ACK   = 3'b111;
    localparam logic [2:0] C_NACK  = 3'b101;
    localparam logic [2:0] C_STOP  = 3'b100;

    logic        clock = 1'b0;
    logic        reset_n, go, sda_i, busy, finish, ack_error, scl, sda_low;
    logic [2:0]  command;
    logic [15:0] data;
    logic        go1, sda_i1, busy1, finish1, ack_error1, scl1, sda_low1;
    logic [2:0]  command1;
    logic [7:0]  data1;

    logic        slave_low = 1'b0;
    logic [3:0]  nack_resp = 4'b0000;
    logic        obs[$];
    logic        obs1[$];
    int          start_cnt = 0;
    int          stop_cnt  = 0;
    int          rcnt      = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    logic [31:0] exp_vec;
    int          exp_n;
    int          exp_lat;
    logic        exp_err;

    always #5 clock = ~clock;

    assign sda_i  = ~(sda_low | slave_low);
    assign sda_i1 = ~sda_low1;

    i2c_master_write_frame #(.BYTES(2), .QUARTER(Q), .LSB_FIRST(0)) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .command(command), .data(data),
        .sda_i(sda_i), .busy(busy), .finish(finish), .ack_error(ack_error),
        .scl(scl), .sda_low(sda_low)
    );

    i2c_master_write_frame #(.BYTES(1), .QUARTER(Q1), .LSB_FIRST(1)) dut_lsb (
        .clock(clock), .reset_n(reset_n), .go(go1), .command(command1), .data(data1),
        .sda_i(sda_i1), .busy(busy1), .finish(finish1), .ack_error(ack_error1),
        .scl(scl1), .sda_low(sda_low1)
    );

    // Bus monitor plus slave for the MSB-first instance.
    initial begin
        logic scl_p, line_p, busy_p, line;
        scl_p = 1'b1; line_p = 1'b1; busy_p = 1'b0;
        forever begin
            @(negedge clock);
            line = ~(sda_low | slave_low);
            if (!reset_n) begin
                rcnt = 0;
                slave_low = 1'b0;
            end else begin
                if (busy && !busy_p) begin
                    rcnt = 0;
                    slave_low = 1'b0;
                end
                if (scl_p && scl && line_p && !line) start_cnt++;
                if (scl_p && scl && !line_p && line) stop_cnt++;
                if (!scl_p && scl) begin
                    obs.push_back(line);
                    rcnt++;
                end
                if (scl_p && !scl && rcnt > 0) begin
                    if (rcnt % 9 == 8) slave_low = ~nack_resp[rcnt / 9];
                    else if (rcnt % 9 == 0) slave_low = 1'b0;
                end
            end
            scl_p = scl; line_p = line; busy_p = busy;
        end
    end

    initial begin
        logic scl_p;
        scl_p = 1'b1;
        forever begin
            @(negedge clock);
            if (!scl_p && scl1) obs1.push_back(~sda_low1);
            scl_p = scl1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic send(input logic [2:0] c, input logic [15:0] d,
                        output int lat, output logic busy_seen, output logic err_seen);
        @(negedge clock);
        command = c; data = d; go = 1'b1;
        @(posedge clock);
        #1 go = 1'b0;
        busy_seen = busy;
        err_seen  = ack_error;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!finish && lat < LIMIT);
    endtask

    task automatic send1(input logic [2:0] c, input logic [7:0] d, output int lat);
        @(negedge clock);
        command1 = c; data1 = d; go1 = 1'b1;
        @(posedge clock);
        #1 go1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!finish1 && lat < LIMIT);
    endtask

    task automatic get_obs(input int base, output logic [31:0] v, output int n);
        v = '0; n = 0;
        for (int i = base; i < obs.size(); i++) begin
            v = {v[30:0], obs[i]};
            n++;
        end
    endtask

    task automatic get_obs1(input int base, output logic [31:0] v, output int n);
        v = '0; n = 0;
        for (int i = base; i < obs1.size(); i++) begin
            v = {v[30:0], obs1[i]};
            n++;
        end
    endtask

    // Reference: MSB-first bytes, each followed by the slave's ACK level; a NACK ends the frame.
    task automatic build_expect(input logic [15:0] d, input logic [3:0] nk);
        int sent;
        sent = 0; exp_vec = '0; exp_n = 0; exp_err = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int b = 0; b < 8; b++) begin
                exp_vec = {exp_vec[30:0], d[15 - (8 * j + b)]};
                exp_n++;
            end
            sent++;
            exp_vec = {exp_vec[30:0], nk[j]};
            exp_n++;
            if (nk[j]) begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_lat = 9 * sent * 4 * Q + 1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        n_checks++; if (scl !== 1'b1)       begin n_errors++; $display("FAIL reset_scl got %b want 1", scl); end
        n_checks++; if (sda_low !== 1'b0)   begin n_errors++; $display("FAIL reset_sda_low got %b want 0", sda_low); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (finish !== 1'b0)    begin n_errors++; $display("FAIL reset_finish got %b want 0", finish); end
        n_checks++; if (ack_error !== 1'b0) begin n_errors++; $display("FAIL reset_ack_error got %b want 0", ack_error); end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0 || scl !== 1'b1) begin
            n_errors++; $display("FAIL post_reset_idle busy=%b scl=%b want 0/1", busy, scl);
        end
    endtask

    task automatic test_start_stop;
        int lat, s0, p0;
        logic bs, es;
        s0 = start_cnt; p0 = stop_cnt;
        send(C_START, 16'h0000, lat, bs, es);
        n_checks++; if (lat !== 4 * Q + 1) begin n_errors++; $display("FAIL start_latency got %0d want %0d", lat, 4 * Q + 1); end
        n_checks++; if (bs !== 1'b1) begin n_errors++; $display("FAIL start_busy got %b want 1", bs); end
        n_checks++; if (start_cnt - s0 !== 1) begin n_errors++; $display("FAIL start_condition got %0d want 1", start_cnt - s0); end
        n_checks++; if ({scl, sda_low} !== 2'b11) begin n_errors++; $display("FAIL start_hold got %b want 11", {scl, sda_low}); end
        send(C_STOP, 16'h0000, lat, bs, es);
        n_checks++; if (lat !== 4 * Q + 1) begin n_errors++; $display("FAIL stop_latency got %0d want %0d", lat, 4 * Q + 1); end
        n_checks++; if (stop_cnt - p0 !== 1) begin n_errors++; $display("FAIL stop_condition got %0d want 1", stop_cnt - p0); end
        n_checks++; if (start_cnt - s0 !== 1) begin n_errors++; $display("FAIL stop_spurious_start got %0d want 1", start_cnt - s0); end
        n_checks++; if ({scl, sda_low} !== 2'b10) begin n_errors++; $display("FAIL stop_hold got %b want 10", {scl, sda_low}); end
    endtask

    task automatic test_data_fixed;
        int lat, base, n;
        logic bs, es;
        logic [31:0] v;
        nack_resp = 4'b0000;
        base = obs.size();
        send(C_DATA, 16'hA55A, lat, bs, es);
        get_obs(base, v, n);
        n_checks++; if (lat !== 289) begin n_errors++; $display("FAIL data_latency got %0d want 289", lat); end
        n_checks++; if (n !== 18) begin n_errors++; $display("FAIL data_bitcount got %0d want 18", n); end
        n_checks++; if (v !== 32'b10100101_0_01011010_0) begin n_errors++; $display("FAIL data_bits got %b want %b", v, 32'b10100101_0_01011010_0); end
        n_checks++; if (ack_error !== 1'b0) begin n_errors++; $display("FAIL data_ack_error got %b want 0", ack_error); end
        n_checks++; if (scl !== 1'b0) begin n_errors++; $display("FAIL data_scl_hold got %b want 0", scl); end
    endtask

    task automatic test_nack_first;
        int lat, base, n;
        logic bs, es;
        logic [31:0] v;
        nack_resp = 4'b0001;
        base = obs.size();
        send(C_DATA, 16'hA55A, lat, bs, es);
        get_obs(base, v, n);
        n_checks++; if (lat !== 145) begin n_errors++; $display("FAIL nack_latency got %0d want 145", lat); end
        n_checks++; if (n !== 9 || v !== 32'b10100101_1) begin n_errors++; $display("FAIL nack_bits got %0d:%b want 9:%b", n, v, 32'b10100101_1); end
        n_checks++; if (ack_error !== 1'b1) begin n_errors++; $display("FAIL nack_ack_error got %b want 1", ack_error); end
        nack_resp = 4'b0000;
        send(C_STOP, 16'h0000, lat, bs, es);
        n_checks++; if (es !== 1'b0) begin n_errors++; $display("FAIL nack_clear got %b want 0", es); end
        n_checks++; if (lat !== 4 * Q + 1) begin n_errors++; $display("FAIL nack_stop_latency got %0d want %0d", lat, 4 * Q + 1); end
    endtask

    task automatic test_lsb_first;
        int lat, base, n;
        logic [31:0] v;
        logic [7:0] d;
        logic [31:0] want;
        for (int it = 0; it < 3; it++) begin
            d = (it == 0) ? 8'h01 : 8'($urandom);
            want = '0;
            for (int k = 0; k < 8; k++) want = {want[30:0], d[k]};
            want = {want[30:0], 1'b1};
            base = obs1.size();
            send1(C_DATA, d, lat);
            get_obs1(base, v, n);
            n_checks++; if (n !== 9 || v !== want) begin n_errors++; $display("FAIL lsb_bits[%0d] got %0d:%b want 9:%b", it, n, v, want); end
            n_checks++; if (lat !== 9 * 4 * Q1 + 1) begin n_errors++; $display("FAIL lsb_latency[%0d] got %0d want %0d", it, lat, 9 * 4 * Q1 + 1); end
            n_checks++; if (ack_error1 !== 1'b1) begin n_errors++; $display("FAIL lsb_ack_error[%0d] got %b want 1", it, ack_error1); end
        end
    endtask

    task automatic test_illegal;
        logic [8:0] codes;
        logic [2:0] c;
        logic scl0, sda0;
        int hits, moves;
        codes = 9'b010_000_110;
        for (int i = 0; i < 3; i++) begin
            c = codes[3 * i +: 3];
            scl0 = scl; sda0 = sda_low; hits = 0; moves = 0;
            @(negedge clock);
            go = 1'b1; command = c;
            repeat (20) begin
                @(negedge clock);
                if (busy || finish) hits++;
                if (scl !== scl0 || sda_low !== sda0) moves++;
            end
            go = 1'b0;
            n_checks++; if (hits !== 0) begin n_errors++; $display("FAIL illegal_%b_busy_finish got %0d want 0", c, hits); end
            n_checks++; if (moves !== 0) begin n_errors++; $display("FAIL illegal_%b_bus_activity got %0d want 0", c, moves); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, base, n, hits;
        logic [31:0] v;
        nack_resp = 4'b0000;
        build_expect(16'h3CC3, 4'b0000);
        base = obs.size();
        @(negedge clock);
        command = C_DATA; data = 16'h3CC3; go = 1'b1;
        @(posedge clock);
        #1 go = 1'b0;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (!finish) begin
                go = (lat % 37 == 5);
                command = C_START;
            end
        end while (!finish && lat < LIMIT);
        go = 1'b1; command = C_STOP;
        @(posedge clock);
        #1 go = 1'b0;
        get_obs(base, v, n);
        n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_lat); end
        n_checks++; if (n !== exp_n || v !== exp_vec) begin n_errors++; $display("FAIL b2b_bits got %0d:%b want %0d:%b", n, v, exp_n, exp_vec); end
        hits = 0;
        repeat (30) begin
            @(negedge clock);
            if (busy || finish) hits++;
        end
        n_checks++; if (hits !== 0) begin n_errors++; $display("FAIL b2b_go_in_finish got %0d want 0", hits); end
    endtask

    task automatic test_random;
        int lat, base, n, kind;
        logic bs, es;
        logic [31:0] v;
        logic [15:0] d;
        logic [3:0] nk;
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 3);
            base = obs.size();
            if (kind <= 1) begin
                d = 16'($urandom);
                nk = 4'b0000;
                nk[0] = ($urandom_range(0, 3) == 0);
                nk[1] = ($urandom_range(0, 3) == 0);
                nack_resp = nk;
                build_expect(d, nk);
                send(C_DATA, d, lat, bs, es);
                get_obs(base, v, n);
                n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", it, lat, exp_lat); end
                n_checks++; if (n !== exp_n || v !== exp_vec) begin n_errors++; $display("FAIL rnd_bits[%0d] got %0d:%b want %0d:%b", it, n, v, exp_n, exp_vec); end
                n_checks++; if (ack_error !== exp_err) begin n_errors++; $display("FAIL rnd_ack_error[%0d] got %b want %b", it, ack_error, exp_err); end
            end else begin
                send((kind == 2) ? C_ACK : C_NACK, 16'h0000, lat, bs, es);
                get_obs(base, v, n);
                n_checks++; if (lat !== 4 * Q + 1) begin n_errors++; $display("FAIL rnd_mack_latency[%0d] got %0d want %0d", it, lat, 4 * Q + 1); end
                n_checks++; if (n !== 1 || v[0] !== (kind == 3)) begin n_errors++; $display("FAIL rnd_mack_bit[%0d] got %0d:%b want 1:%b", it, n, v[0], (kind == 3)); end
                n_checks++; if (scl !== 1'b0) begin n_errors++; $display("FAIL rnd_mack_hold[%0d] got %b want 0", it, scl); end
            end
        end
        nack_resp = 4'b0000;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic bs, es;
        @(negedge clock);
        command = C_DATA; data = 16'hF0F0; go = 1'b1;
        @(posedge clock);
        #1 go = 1'b0;
        repeat (50) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if ({busy, finish, ack_error, scl, sda_low} !== 5'b00010) begin
            n_errors++; $display("FAIL reset_mid_outputs got %b want 00010", {busy, finish, ack_error, scl, sda_low});
        end
        @(negedge clock);
        reset_n = 1'b1;
        send(C_START, 16'h0000, lat, bs, es);
        n_checks++; if (lat !== 4 * Q + 1) begin n_errors++; $display("FAIL reset_recover_latency got %0d want %0d", lat, 4 * Q + 1); end
    endtask

    initial begin
        reset_n = 1'b0; go = 1'b0; command = 3'b000; data = 16'h0000;
        go1 = 1'b0; command1 = 3'b000; data1 = 8'h00;
        test_reset;
        test_start_stop;
        test_data_fixed;
        test_nack_first;
        test_lsb_first;
        test_illegal;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
